// File: rtl/agc_loop_sequencer.sv
// agc_loop_sequencer - mode controller for the amplitude-control loop.
// Sequences IDLE/ACQ/TRACK/HOLD, drives gain reload, step size, freeze and power target, reports lock.
module agc_loop_sequencer #(
  parameter logic [15:0] C_INIT       = 16'd256,
  parameter logic [15:0] POWER_TARGET = 16'd4096,
  parameter logic [31:0] LOCK_THR     = 32'd512,
  parameter logic [31:0] UNLOCK_THR   = 32'd2048,
  parameter logic [15:0] LOCK_CNT     = 16'd16,
  parameter logic [15:0] UNLOCK_CNT   = 16'd8,
  parameter logic [15:0] ACQ_TIMEOUT  = 16'd1024,
  parameter logic [15:0] GAP_CYC      = 16'd64,
  parameter logic [3:0]  MU_ACQ       = 4'd4,
  parameter logic [3:0]  MU_TRK       = 4'd8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_i,
  input  logic [15:0] target_cfg_i,
  input  logic        valid_i,
  input  logic [31:0] eps_i,
  input  logic        valid_eps_i,
  output logic [15:0] power_target_o,
  output logic [15:0] c_init_o,
  output logic        c_load_o,
  output logic [3:0]  mu_shift_o,
  output logic        freeze_o,
  output logic        lock_o,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACQ   = 2'b01,
    TRACK = 2'b10,
    HOLD  = 2'b11
  } state_t;

  state_t      state;
  state_t      ret_state;
  logic [15:0] good_cnt;
  logic [15:0] bad_cnt;
  logic [15:0] tmo_cnt;
  logic [15:0] gap_cnt;
  logic        ev_valid;
  logic        ev_good;
  logic        ev_bad;
  logic [31:0] eps_mag;
  logic [15:0] good_inc;
  logic [15:0] bad_inc;
  logic [15:0] tmo_inc;
  logic [15:0] gap_next;
  logic        gap_hit;

  // -2^31 has no positive counterpart, so it saturates to the largest magnitude.
  always_comb begin
    eps_mag = eps_i;
    if (eps_i == 32'h8000_0000) begin
      eps_mag = 32'h7FFF_FFFF;
    end else if (eps_i[31]) begin
      eps_mag = -eps_i;
    end
  end

  assign good_inc = (good_cnt == 16'hFFFF) ? good_cnt : good_cnt + 16'd1;
  assign bad_inc  = (bad_cnt  == 16'hFFFF) ? bad_cnt  : bad_cnt  + 16'd1;
  assign tmo_inc  = (tmo_cnt  == 16'hFFFF) ? tmo_cnt  : tmo_cnt  + 16'd1;

  always_comb begin
    gap_next = gap_cnt;
    if (valid_i) begin
      gap_next = 16'd0;
    end else if (gap_cnt < GAP_CYC) begin
      gap_next = gap_cnt + 16'd1;
    end
  end

  assign gap_hit = (gap_next >= GAP_CYC);
  assign state_o = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      ret_state      <= IDLE;
      good_cnt       <= 16'd0;
      bad_cnt        <= 16'd0;
      tmo_cnt        <= 16'd0;
      gap_cnt        <= 16'd0;
      ev_valid       <= 1'b0;
      ev_good        <= 1'b0;
      ev_bad         <= 1'b0;
      power_target_o <= POWER_TARGET;
      c_init_o       <= C_INIT;
      c_load_o       <= 1'b0;
      mu_shift_o     <= MU_ACQ;
      freeze_o       <= 1'b1;
      lock_o         <= 1'b0;
    end else begin
      c_load_o <= 1'b0;
      // eps samples are classified one edge before they act on the counters.
      ev_valid <= valid_eps_i && enable_i && ((state == ACQ) || (state == TRACK));
      ev_good  <= (eps_mag < LOCK_THR);
      ev_bad   <= (eps_mag >= UNLOCK_THR);

      if (!enable_i) begin
        state      <= IDLE;
        lock_o     <= 1'b0;
        freeze_o   <= 1'b1;
        mu_shift_o <= MU_ACQ;
        good_cnt   <= 16'd0;
        bad_cnt    <= 16'd0;
        tmo_cnt    <= 16'd0;
        gap_cnt    <= 16'd0;
      end else begin
        case (state)
          IDLE: begin
            state          <= ACQ;
            power_target_o <= target_cfg_i;
            c_load_o       <= 1'b1;
            freeze_o       <= 1'b0;
            mu_shift_o     <= MU_ACQ;
          end

          ACQ, TRACK: begin
            gap_cnt <= gap_next;
            if (gap_hit) begin
              ret_state <= state;
              state     <= HOLD;
              freeze_o  <= 1'b1;
            end else if (ev_valid && (state == ACQ)) begin
              if (ev_good && (good_inc >= LOCK_CNT)) begin
                state      <= TRACK;
                lock_o     <= 1'b1;
                mu_shift_o <= MU_TRK;
                good_cnt   <= 16'd0;
                bad_cnt    <= 16'd0;
                tmo_cnt    <= 16'd0;
              end else if (tmo_inc >= ACQ_TIMEOUT) begin
                c_load_o <= 1'b1;
                tmo_cnt  <= 16'd0;
                good_cnt <= 16'd0;
              end else begin
                tmo_cnt  <= tmo_inc;
                good_cnt <= ev_good ? good_inc : 16'd0;
              end
            end else if (ev_valid && (state == TRACK)) begin
              if (ev_bad && (bad_inc >= UNLOCK_CNT)) begin
                state      <= ACQ;
                lock_o     <= 1'b0;
                mu_shift_o <= MU_ACQ;
                good_cnt   <= 16'd0;
                bad_cnt    <= 16'd0;
                tmo_cnt    <= 16'd0;
              end else begin
                bad_cnt <= ev_bad ? bad_inc : 16'd0;
              end
            end
          end

          HOLD: begin
            if (valid_i) begin
              state    <= ret_state;
              freeze_o <= 1'b0;
              good_cnt <= 16'd0;
              bad_cnt  <= 16'd0;
              gap_cnt  <= 16'd0;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_agc_loop_sequencer.sv
// tb_agc_loop_sequencer - directed and randomized checks of agc_loop_sequencer against a rule-level model.
module tb_agc_loop_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable_i = 1'b1;
  logic [15:0] target_cfg_i = 16'h1234;
  logic        valid_i = 1'b1;
  logic [31:0] eps_i = 32'd0;
  logic        valid_eps_i = 1'b0;
  logic [15:0] power_target_o;
  logic [15:0] c_init_o;
  logic        c_load_o;
  logic [3:0]  mu_shift_o;
  logic        freeze_o;
  logic        lock_o;
  logic [1:0]  state_o;

  int n_tests = 0;
  int n_fail  = 0;

  agc_loop_sequencer dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .target_cfg_i(target_cfg_i),
    .valid_i(valid_i), .eps_i(eps_i), .valid_eps_i(valid_eps_i),
    .power_target_o(power_target_o), .c_init_o(c_init_o), .c_load_o(c_load_o),
    .mu_shift_o(mu_shift_o), .freeze_o(freeze_o), .lock_o(lock_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 acquire, 2 track, 3 hold.
  int          m_phase, m_ret, m_good, m_bad, m_tmo, m_gap, m_mu;
  bit          m_lock, m_freeze, m_cload;
  logic [15:0] m_pt;
  bit          p_seen;
  int          p_kind;   // 0 good, 1 in-between, 2 bad

  function automatic int kind_of(logic [31:0] e);
    longint m;
    m = longint'($signed(e));
    if (m < 0) m = -m;
    if (m > 64'sd2147483647) m = 64'sd2147483647;
    if (m < 512) return 0;
    if (m >= 2048) return 2;
    return 1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_ret = 0; m_good = 0; m_bad = 0; m_tmo = 0; m_gap = 0;
    m_mu = 4; m_lock = 0; m_freeze = 1; m_cload = 0; m_pt = 16'd4096;
    p_seen = 0; p_kind = 1;
  endtask

  task automatic model_step();
    bit nseen;
    int nkind;
    nseen = valid_eps_i && enable_i && (m_phase == 1 || m_phase == 2);
    nkind = kind_of(eps_i);
    m_cload = 0;
    if (!enable_i) begin
      m_phase = 0; m_lock = 0; m_freeze = 1; m_mu = 4;
      m_good = 0; m_bad = 0; m_tmo = 0; m_gap = 0;
    end else if (m_phase == 0) begin
      m_phase = 1; m_pt = target_cfg_i; m_cload = 1; m_freeze = 0; m_mu = 4;
    end else if (m_phase == 3) begin
      if (valid_i) begin
        m_phase = m_ret; m_freeze = 0; m_good = 0; m_bad = 0; m_gap = 0;
      end
    end else begin
      m_gap = valid_i ? 0 : ((m_gap + 1 > 64) ? 64 : m_gap + 1);
      if (m_gap >= 64) begin
        m_ret = m_phase; m_phase = 3; m_freeze = 1;
      end else if (p_seen && m_phase == 1) begin
        m_good = (p_kind == 0) ? m_good + 1 : 0;
        m_tmo  = m_tmo + 1;
        if (m_good >= 16) begin
          m_phase = 2; m_lock = 1; m_mu = 8; m_good = 0; m_bad = 0; m_tmo = 0;
        end else if (m_tmo >= 1024) begin
          m_cload = 1; m_tmo = 0; m_good = 0;
        end
      end else if (p_seen && m_phase == 2) begin
        m_bad = (p_kind == 2) ? m_bad + 1 : 0;
        if (m_bad >= 8) begin
          m_phase = 1; m_lock = 0; m_mu = 4; m_good = 0; m_bad = 0; m_tmo = 0;
        end
      end
    end
    p_seen = nseen;
    p_kind = nkind;
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("state", 32'(state_o), 32'(m_phase));
    chk("lock", 32'(lock_o), 32'(m_lock));
    chk("freeze", 32'(freeze_o), 32'(m_freeze));
    chk("mu_shift", 32'(mu_shift_o), 32'(m_mu));
    chk("c_load", 32'(c_load_o), 32'(m_cload));
    chk("power_target", 32'(power_target_o), 32'(m_pt));
    chk("c_init", 32'(c_init_o), 32'd256);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_step();
    #1;
    check_all();
  endtask

  function automatic logic [31:0] rand_eps(int kind);
    logic [31:0] mag;
    case (kind)
      0:       mag = 32'($urandom_range(0, 511));
      1:       mag = 32'($urandom_range(512, 2047));
      default: mag = 32'(2048 + ($urandom % 32'h0FFF_FFFF));
    endcase
    return $urandom_range(0, 1) ? -mag : mag;
  endfunction

  task automatic feed(int kind, int n);
    for (int i = 0; i < n; i++) begin
      valid_i = 1; valid_eps_i = 1; eps_i = rand_eps(kind);
      step();
    end
    valid_eps_i = 0;
  endtask

  int cl;

  initial begin
    model_reset();
    // Reset with enable already high
    repeat (3) step();
    chk("t1_reset_state", 32'(state_o), 32'd0);
    chk("t1_reset_freeze", 32'(freeze_o), 32'd1);
    chk("t1_reset_mu", 32'(mu_shift_o), 32'd4);
    chk("t1_reset_pt", 32'(power_target_o), 32'd4096);
    target_cfg_i = 16'($urandom);
    rst = 1;
    step();
    chk("t1_acq_state", 32'(state_o), 32'd1);
    chk("t1_cload_first", 32'(c_load_o), 32'd1);
    chk("t1_pt_loaded", 32'(power_target_o), 32'(target_cfg_i));
    target_cfg_i = ~target_cfg_i;
    step();
    chk("t1_cload_once", 32'(c_load_o), 32'd0);

    // Lock after 16 good samples
    valid_i = 1; valid_eps_i = 1; eps_i = 32'd100;
    repeat (16) step();
    valid_eps_i = 0;
    step();
    chk("t2_track", 32'(state_o), 32'd2);
    chk("t2_lock", 32'(lock_o), 32'd1);
    chk("t2_mu", 32'(mu_shift_o), 32'd8);

    // Unlock after 8 samples of -3000
    valid_eps_i = 1; eps_i = -32'd3000;
    repeat (8) step();
    valid_eps_i = 0;
    step();
    chk("t3_acq", 32'(state_o), 32'd1);
    chk("t3_unlock", 32'(lock_o), 32'd0);
    chk("t3_mu", 32'(mu_shift_o), 32'd4);

    // 15 good, 1 bad, 15 good stays in ACQ; one more good locks
    feed(0, 15); feed(2, 1); feed(0, 15);
    step();
    chk("t2_broken_run", 32'(state_o), 32'd1);
    feed(0, 1);
    step();
    chk("t2_relock", 32'(state_o), 32'd2);

    // -2^31 counts as a bad sample
    feed(2, 7);
    valid_eps_i = 1; eps_i = 32'h8000_0000;
    step();
    valid_eps_i = 0;
    step();
    chk("t3_minint_bad", 32'(state_o), 32'd1);

    // Acquisition timeout
    cl = 0;
    valid_eps_i = 1; eps_i = 32'd10000;
    for (int i = 0; i < 1024; i++) begin
      step();
      if (c_load_o) cl++;
    end
    valid_eps_i = 0;
    step();
    if (c_load_o) cl++;
    chk("t4_cload_count", 32'(cl), 32'd1);
    chk("t4_still_acq", 32'(state_o), 32'd1);
    feed(0, 16);
    step();
    chk("t4_track_after", 32'(state_o), 32'd2);

    // Input gap into HOLD and back
    valid_i = 0;
    repeat (63) step();
    chk("t5_before_gap", 32'(state_o), 32'd2);
    step();
    chk("t5_hold", 32'(state_o), 32'd3);
    chk("t5_hold_freeze", 32'(freeze_o), 32'd1);
    chk("t5_hold_lock", 32'(lock_o), 32'd1);
    valid_i = 1;
    step();
    chk("t5_return", 32'(state_o), 32'd2);

    // enable low on the edge the 16th good sample would lock
    feed(2, 8);
    step();
    feed(0, 16);
    enable_i = 0;
    step();
    chk("t6_idle", 32'(state_o), 32'd0);
    chk("t6_nolock", 32'(lock_o), 32'd0);
    chk("t6_no_cload", 32'(c_load_o), 32'd0);
    enable_i = 1;
    step();
    feed(0, 16);
    step();
    chk("t6_track", 32'(state_o), 32'd2);

    // Asynchronous reset mid-cycle
    #2;
    rst = 0;
    model_reset();
    #1;
    chk("t6_async_state", 32'(state_o), 32'd0);
    chk("t6_async_lock", 32'(lock_o), 32'd0);
    chk("t6_async_freeze", 32'(freeze_o), 32'd1);
    step();
    rst = 1;
    target_cfg_i = 16'($urandom);
    step();

    // Randomized phases against the model
    for (int b = 0; b < 60; b++) begin
      int mode;
      int len;
      mode = $urandom_range(0, 5);
      len  = $urandom_range(10, 60);
      target_cfg_i = 16'($urandom);
      case (mode)
        3: begin
          valid_i = 0; valid_eps_i = 0;
          repeat ($urandom_range(55, 75)) step();
          valid_i = 1;
        end
        4: begin
          enable_i = 0;
          repeat ($urandom_range(1, 3)) step();
          enable_i = 1;
        end
        default: begin
          for (int i = 0; i < len; i++) begin
            int k;
            k = (mode == 0) ? 0 : (mode == 1) ? 2 : $urandom_range(0, 2);
            if ($urandom_range(0, 9) == 0) k = $urandom_range(0, 2);
            valid_i = ($urandom_range(0, 7) != 0);
            valid_eps_i = ($urandom_range(0, 9) < 7);
            eps_i = rand_eps(k);
            step();
          end
          valid_eps_i = 0;
          valid_i = 1;
        end
      endcase
    end
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
